// File: rtl/br_issue_sched.sv
// Branch reservation station and issue scheduler.
// Holds dispatched branch/jump ops, wakes operands from the CDB, issues the oldest ready op.
module br_issue_sched #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int OP_W   = 4,
  localparam int IW    = $clog2(DEPTH),
  localparam int CW    = IW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_disp_vld,
  output logic              o_disp_rdy,
  input  logic              i_disp_is_jal,
  input  logic              i_disp_is_jalr,
  input  logic [OP_W-1:0]   i_disp_alu_op,
  input  logic [PC_W-1:0]   i_disp_pc,
  input  logic [DATA_W-1:0] i_disp_imm,
  input  logic [PC_W-1:0]   i_disp_pred_jmpaddr,
  input  logic              i_disp_rs1_rdy,
  input  logic [DATA_W-1:0] i_disp_rs1,
  input  logic [TAG_W-1:0]  i_disp_rs1_tag,
  input  logic              i_disp_rs2_rdy,
  input  logic [DATA_W-1:0] i_disp_rs2,
  input  logic [TAG_W-1:0]  i_disp_rs2_tag,
  input  logic              i_cdb_vld,
  input  logic [TAG_W-1:0]  i_cdb_tag,
  input  logic [DATA_W-1:0] i_cdb_data,
  input  logic              i_ex_accessable,
  input  logic              i_kill,
  output logic              o_is_vld,
  output logic              o_is_jal,
  output logic              o_is_jalr,
  output logic [OP_W-1:0]   o_alu_op,
  output logic [DATA_W-1:0] o_rs1,
  output logic [DATA_W-1:0] o_rs2,
  output logic [PC_W-1:0]   o_pc,
  output logic [DATA_W-1:0] o_imm,
  output logic [PC_W-1:0]   o_pred_jmpaddr,
  output logic [CW-1:0]     o_count
);

  typedef struct packed {
    logic              is_jal;
    logic              is_jalr;
    logic [OP_W-1:0]   op;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   pja;
    logic              rs1_rdy;
    logic [DATA_W-1:0] rs1;
    logic [TAG_W-1:0]  rs1_tag;
    logic              rs2_rdy;
    logic [DATA_W-1:0] rs2;
    logic [TAG_W-1:0]  rs2_tag;
  } ent_t;

  ent_t             r_ent [DEPTH];
  logic [DEPTH-1:0] r_vld;
  // r_age[i][j] set means entry i is older than entry j
  logic [DEPTH-1:0] r_age [DEPTH];
  logic [CW-1:0]    r_count;

  logic              r_is_vld;
  logic              r_is_jal;
  logic              r_is_jalr;
  logic [OP_W-1:0]   r_alu_op;
  logic [DATA_W-1:0] r_rs1;
  logic [DATA_W-1:0] r_rs2;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_imm;
  logic [PC_W-1:0]   r_pja;

  logic             w_accept;
  logic [IW-1:0]    w_alloc_idx;
  logic             w_d1_hit;
  logic             w_d2_hit;
  ent_t             w_new;
  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_win;
  logic [IW-1:0]    w_sel_idx;
  logic             w_issue;

  assign o_disp_rdy = (r_count != CW'(DEPTH));
  assign w_accept   = i_disp_vld & o_disp_rdy & ~i_kill;
  assign w_d1_hit   = ~i_disp_rs1_rdy & i_cdb_vld & (i_disp_rs1_tag == i_cdb_tag);
  assign w_d2_hit   = ~i_disp_rs2_rdy & i_cdb_vld & (i_disp_rs2_tag == i_cdb_tag);

  // Lowest free slot and the new entry image, with same-cycle CDB capture
  always_comb begin
    w_alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_vld[i]) w_alloc_idx = IW'(i);
    end
    w_new.is_jal  = i_disp_is_jal;
    w_new.is_jalr = i_disp_is_jalr;
    w_new.op      = i_disp_alu_op;
    w_new.pc      = i_disp_pc;
    w_new.imm     = i_disp_imm;
    w_new.pja     = i_disp_pred_jmpaddr;
    w_new.rs1_rdy = i_disp_rs1_rdy | w_d1_hit;
    w_new.rs1     = w_d1_hit ? i_cdb_data : i_disp_rs1;
    w_new.rs1_tag = i_disp_rs1_tag;
    w_new.rs2_rdy = i_disp_rs2_rdy | w_d2_hit;
    w_new.rs2     = w_d2_hit ? i_cdb_data : i_disp_rs2;
    w_new.rs2_tag = i_disp_rs2_tag;
  end

  // Oldest ready entry: ready and older than every other ready entry
  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_ready[i] = r_vld[i] & r_ent[i].rs1_rdy & r_ent[i].rs2_rdy;
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_win[i] = w_ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && w_ready[j] && !r_age[i][j]) w_win[i] = 1'b0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (w_win[i]) w_sel_idx = IW'(i);
    end
  end

  assign w_issue = (|w_ready) & i_ex_accessable & ~i_kill;

  // Entry storage: allocate, wake up held operands, retire on issue, flush on kill
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else if (i_kill) begin
      r_vld <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_issue && w_sel_idx == IW'(i)) r_vld[i] <= 1'b0;
        if (w_accept && w_alloc_idx == IW'(i)) begin
          r_vld[i] <= 1'b1;
          r_ent[i] <= w_new;
          for (int j = 0; j < DEPTH; j++) begin
            r_age[i][j] <= 1'b0;
            r_age[j][i] <= r_vld[j];
          end
        end else if (r_vld[i] && i_cdb_vld) begin
          if (!r_ent[i].rs1_rdy && r_ent[i].rs1_tag == i_cdb_tag) begin
            r_ent[i].rs1_rdy <= 1'b1;
            r_ent[i].rs1     <= i_cdb_data;
          end
          if (!r_ent[i].rs2_rdy && r_ent[i].rs2_tag == i_cdb_tag) begin
            r_ent[i].rs2_rdy <= 1'b1;
            r_ent[i].rs2     <= i_cdb_data;
          end
        end
      end
    end
  end

  // Issue registers and occupancy count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_is_vld  <= 1'b0;
      r_is_jal  <= 1'b0;
      r_is_jalr <= 1'b0;
      r_alu_op  <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_pc      <= '0;
      r_imm     <= '0;
      r_pja     <= '0;
      r_count   <= '0;
    end else if (i_kill) begin
      r_is_vld <= 1'b0;
      r_count  <= '0;
    end else begin
      r_is_vld <= w_issue;
      if (w_issue) begin
        r_is_jal  <= r_ent[w_sel_idx].is_jal;
        r_is_jalr <= r_ent[w_sel_idx].is_jalr;
        r_alu_op  <= r_ent[w_sel_idx].op;
        r_rs1     <= r_ent[w_sel_idx].rs1;
        r_rs2     <= r_ent[w_sel_idx].rs2;
        r_pc      <= r_ent[w_sel_idx].pc;
        r_imm     <= r_ent[w_sel_idx].imm;
        r_pja     <= r_ent[w_sel_idx].pja;
      end
      r_count <= r_count + CW'(w_accept) - CW'(w_issue);
    end
  end

  assign o_is_vld       = r_is_vld;
  assign o_is_jal       = r_is_jal;
  assign o_is_jalr      = r_is_jalr;
  assign o_alu_op       = r_alu_op;
  assign o_rs1          = r_rs1;
  assign o_rs2          = r_rs2;
  assign o_pc           = r_pc;
  assign o_imm          = r_imm;
  assign o_pred_jmpaddr = r_pja;
  assign o_count        = r_count;

endmodule

// File: tb/tb_br_issue_sched.sv
// Testbench for br_issue_sched.
// Queue-based age-ordered model plus directed scenarios with literal pins.
module tb_br_issue_sched;
  localparam int DEPTH = 4;

  logic        clk = 0;
  logic        rst_n;
  logic        i_disp_vld;
  logic        o_disp_rdy;
  logic        i_disp_is_jal;
  logic        i_disp_is_jalr;
  logic [3:0]  i_disp_alu_op;
  logic [31:0] i_disp_pc;
  logic [31:0] i_disp_imm;
  logic [31:0] i_disp_pred_jmpaddr;
  logic        i_disp_rs1_rdy;
  logic [31:0] i_disp_rs1;
  logic [5:0]  i_disp_rs1_tag;
  logic        i_disp_rs2_rdy;
  logic [31:0] i_disp_rs2;
  logic [5:0]  i_disp_rs2_tag;
  logic        i_cdb_vld;
  logic [5:0]  i_cdb_tag;
  logic [31:0] i_cdb_data;
  logic        i_ex_accessable;
  logic        i_kill;
  logic        o_is_vld;
  logic        o_is_jal;
  logic        o_is_jalr;
  logic [3:0]  o_alu_op;
  logic [31:0] o_rs1;
  logic [31:0] o_rs2;
  logic [31:0] o_pc;
  logic [31:0] o_imm;
  logic [31:0] o_pred_jmpaddr;
  logic [2:0]  o_count;

  br_issue_sched dut (
    .clk(clk), .rst_n(rst_n),
    .i_disp_vld(i_disp_vld), .o_disp_rdy(o_disp_rdy),
    .i_disp_is_jal(i_disp_is_jal), .i_disp_is_jalr(i_disp_is_jalr),
    .i_disp_alu_op(i_disp_alu_op), .i_disp_pc(i_disp_pc),
    .i_disp_imm(i_disp_imm), .i_disp_pred_jmpaddr(i_disp_pred_jmpaddr),
    .i_disp_rs1_rdy(i_disp_rs1_rdy), .i_disp_rs1(i_disp_rs1),
    .i_disp_rs1_tag(i_disp_rs1_tag), .i_disp_rs2_rdy(i_disp_rs2_rdy),
    .i_disp_rs2(i_disp_rs2), .i_disp_rs2_tag(i_disp_rs2_tag),
    .i_cdb_vld(i_cdb_vld), .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data),
    .i_ex_accessable(i_ex_accessable), .i_kill(i_kill),
    .o_is_vld(o_is_vld), .o_is_jal(o_is_jal), .o_is_jalr(o_is_jalr),
    .o_alu_op(o_alu_op), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_pc(o_pc),
    .o_imm(o_imm), .o_pred_jmpaddr(o_pred_jmpaddr), .o_count(o_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  typedef struct {
    bit          jal;
    bit          jalr;
    logic [3:0]  op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] pja;
    bit          r1r;
    logic [31:0] r1;
    logic [5:0]  t1;
    bit          r2r;
    logic [31:0] r2;
    logic [5:0]  t2;
  } m_ent_t;

  // Model: queue kept in dispatch order, so the front-most ready entry is the oldest
  m_ent_t      mq[$];
  m_ent_t      ne;
  bit          m_vld;
  m_ent_t      m_out;

  always @(posedge clk) begin : model
    int sel;
    int n0;
    if (!rst_n) begin
      mq.delete();
      m_vld = 0;
      m_out = '{default: '0};
    end else if (i_kill) begin
      mq.delete();
      m_vld = 0;
    end else begin
      n0 = mq.size();
      sel = -1;
      for (int k = 0; k < mq.size(); k++) begin
        if (mq[k].r1r && mq[k].r2r) begin
          sel = k;
          break;
        end
      end
      if (sel >= 0 && i_ex_accessable) begin
        m_vld = 1;
        m_out = mq[sel];
        mq.delete(sel);
      end else begin
        m_vld = 0;
      end
      if (i_cdb_vld) begin
        for (int k = 0; k < mq.size(); k++) begin
          if (!mq[k].r1r && mq[k].t1 == i_cdb_tag) begin
            mq[k].r1r = 1; mq[k].r1 = i_cdb_data;
          end
          if (!mq[k].r2r && mq[k].t2 == i_cdb_tag) begin
            mq[k].r2r = 1; mq[k].r2 = i_cdb_data;
          end
        end
      end
      if (i_disp_vld && n0 < DEPTH) begin
        ne.jal = i_disp_is_jal;
        ne.jalr = i_disp_is_jalr;
        ne.op = i_disp_alu_op;
        ne.pc = i_disp_pc;
        ne.imm = i_disp_imm;
        ne.pja = i_disp_pred_jmpaddr;
        ne.t1 = i_disp_rs1_tag;
        ne.t2 = i_disp_rs2_tag;
        ne.r1r = i_disp_rs1_rdy;
        ne.r1 = i_disp_rs1;
        ne.r2r = i_disp_rs2_rdy;
        ne.r2 = i_disp_rs2;
        if (!ne.r1r && i_cdb_vld && ne.t1 == i_cdb_tag) begin
          ne.r1r = 1; ne.r1 = i_cdb_data;
        end
        if (!ne.r2r && i_cdb_vld && ne.t2 == i_cdb_tag) begin
          ne.r2r = 1; ne.r2 = i_cdb_data;
        end
        mq.push_back(ne);
      end
    end
  end

  // Compare every cycle against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("is_vld", 64'(o_is_vld), 64'(m_vld));
      chk("count", 64'(o_count), 64'(mq.size()));
      chk("disp_rdy", 64'(o_disp_rdy), 64'(mq.size() != DEPTH));
      chk("pc", 64'(o_pc), 64'(m_out.pc));
      chk("rs1", 64'(o_rs1), 64'(m_out.r1));
      chk("rs2", 64'(o_rs2), 64'(m_out.r2));
      chk("imm", 64'(o_imm), 64'(m_out.imm));
      chk("pja", 64'(o_pred_jmpaddr), 64'(m_out.pja));
      chk("alu_op", 64'(o_alu_op), 64'(m_out.op));
      chk("jal", 64'(o_is_jal), 64'(m_out.jal));
      chk("jalr", 64'(o_is_jalr), 64'(m_out.jalr));
    end
  end

  task automatic clr();
    i_disp_vld = 0; i_disp_is_jal = 0; i_disp_is_jalr = 0;
    i_disp_alu_op = 0; i_disp_pc = 0; i_disp_imm = 0;
    i_disp_pred_jmpaddr = 0;
    i_disp_rs1_rdy = 0; i_disp_rs1 = 0; i_disp_rs1_tag = 0;
    i_disp_rs2_rdy = 0; i_disp_rs2 = 0; i_disp_rs2_tag = 0;
    i_cdb_vld = 0; i_cdb_tag = 0; i_cdb_data = 0;
    i_ex_accessable = 1; i_kill = 0;
  endtask

  task automatic disp(input logic [31:0] pc, input logic [31:0] imm,
                      input bit r1r, input logic [31:0] r1, input logic [5:0] t1,
                      input bit r2r, input logic [31:0] r2, input logic [5:0] t2);
    i_disp_vld = 1; i_disp_pc = pc; i_disp_imm = imm;
    i_disp_alu_op = pc[5:2]; i_disp_pred_jmpaddr = pc + 32'h40;
    i_disp_is_jal = pc[2]; i_disp_is_jalr = pc[3];
    i_disp_rs1_rdy = r1r; i_disp_rs1 = r1; i_disp_rs1_tag = t1;
    i_disp_rs2_rdy = r2r; i_disp_rs2 = r2; i_disp_rs2_tag = t2;
  endtask

  task automatic cdb(input logic [5:0] t, input logic [31:0] d);
    i_cdb_vld = 1; i_cdb_tag = t; i_cdb_data = d;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    clr();
    rst_n = 0;
    @(posedge clk);
    #1 chk_on = 1;
    tick();
    tick();
    chk("rst count", 64'(o_count), 64'd0);
    chk("rst is_vld", 64'(o_is_vld), 64'd0);
    chk("rst pc", 64'(o_pc), 64'd0);

    // Ready BEQ: accept, then issue one edge later
    rst_n = 1;
    disp(32'h100, 32'd8, 1, 32'd5, 6'd1, 1, 32'd5, 6'd2);
    tick();
    clr();
    chk("beq rdy", 64'(o_disp_rdy), 64'd1);
    chk("beq cnt1", 64'(o_count), 64'd1);
    chk("beq early", 64'(o_is_vld), 64'd0);
    tick();
    chk("beq vld", 64'(o_is_vld), 64'd1);
    chk("beq pc", 64'(o_pc), 64'h100);
    chk("beq rs1", 64'(o_rs1), 64'd5);
    chk("beq rs2", 64'(o_rs2), 64'd5);
    chk("beq imm", 64'(o_imm), 64'd8);
    chk("beq cnt0", 64'(o_count), 64'd0);
    tick();
    chk("beq pulse", 64'(o_is_vld), 64'd0);

    // Younger ready op overtakes an older waiting one
    disp(32'h200, 32'd4, 0, 32'd0, 6'd7, 1, 32'd1, 6'd0);
    tick();
    disp(32'h300, 32'd4, 1, 32'd2, 6'd0, 1, 32'd3, 6'd0);
    tick();
    clr();
    tick();
    chk("byp B vld", 64'(o_is_vld), 64'd1);
    chk("byp B pc", 64'(o_pc), 64'h300);
    cdb(6'd7, 32'h55);
    tick();
    clr();
    chk("byp wake", 64'(o_is_vld), 64'd0);
    tick();
    chk("byp A vld", 64'(o_is_vld), 64'd1);
    chk("byp A pc", 64'(o_pc), 64'h200);
    chk("byp A rs1", 64'(o_rs1), 64'h55);
    tick();

    // Fill, refuse a fifth, then drain in dispatch order
    for (int k = 0; k < 4; k++) begin
      disp(32'h400 + 32'(k * 4), 32'(k), 0, 32'd0, 6'd3, 1, 32'd9, 6'd0);
      tick();
    end
    chk("full rdy", 64'(o_disp_rdy), 64'd0);
    chk("full cnt", 64'(o_count), 64'd4);
    disp(32'h500, 32'd0, 1, 32'd1, 6'd0, 1, 32'd1, 6'd0);
    tick();
    clr();
    chk("full ign", 64'(o_count), 64'd4);
    cdb(6'd3, 32'h33);
    tick();
    clr();
    chk("full wake", 64'(o_is_vld), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("order vld", 64'(o_is_vld), 64'd1);
      chk("order pc", 64'(o_pc), 64'(32'h400 + 32'(k * 4)));
    end
    tick();
    chk("order done", 64'(o_is_vld), 64'd0);

    // Same-cycle CDB capture at dispatch
    disp(32'h600, 32'd12, 1, 32'd7, 6'd0, 0, 32'd0, 6'd9);
    cdb(6'd9, 32'h1234);
    tick();
    clr();
    chk("dcdb early", 64'(o_is_vld), 64'd0);
    tick();
    chk("dcdb vld", 64'(o_is_vld), 64'd1);
    chk("dcdb rs2", 64'(o_rs2), 64'h1234);
    chk("dcdb pc", 64'(o_pc), 64'h600);

    // Branch unit busy for three cycles
    disp(32'h700, 32'd16, 1, 32'd1, 6'd0, 1, 32'd2, 6'd0);
    i_ex_accessable = 0;
    tick();
    clr();
    i_ex_accessable = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("busy vld", 64'(o_is_vld), 64'd0);
      chk("busy cnt", 64'(o_count), 64'd1);
    end
    i_ex_accessable = 1;
    tick();
    chk("busy iss", 64'(o_is_vld), 64'd1);
    chk("busy pc", 64'(o_pc), 64'h700);

    // Kill with concurrent dispatch and CDB
    for (int k = 0; k < 3; k++) begin
      disp(32'h800 + 32'(k * 4), 32'd0, 0, 32'd0, 6'd20, 1, 32'd0, 6'd0);
      tick();
    end
    chk("kill pre", 64'(o_count), 64'd3);
    disp(32'h900, 32'd0, 1, 32'd1, 6'd0, 1, 32'd1, 6'd0);
    cdb(6'd20, 32'h77);
    i_kill = 1;
    tick();
    clr();
    chk("kill cnt", 64'(o_count), 64'd0);
    chk("kill vld", 64'(o_is_vld), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("kill quiet", 64'(o_is_vld), 64'd0);
    end
    chk("kill hold pc", 64'(o_pc), 64'h700);

    // Mixed traffic against the model
    for (int c = 0; c < 400; c++) begin
      clr();
      if ($urandom_range(0, 1) == 1)
        disp($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
             6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
             6'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) != 0)
        cdb(6'($urandom_range(0, 7)), $urandom);
      i_ex_accessable = ($urandom_range(0, 3) != 0);
      i_kill = ($urandom_range(0, 49) == 0);
      tick();
    end
    clr();
    for (int c = 0; c < 8; c++) begin
      cdb(6'(c), 32'hA0 + 32'(c));
      tick();
    end
    clr();
    repeat (6) tick();
    chk("drain cnt", 64'(o_count), 64'd0);

    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/br_issue_sched.md
Name: br_issue_sched

Overview:
- Reservation station and issue scheduler in front of the branch execution unit.
- Holds up to DEPTH dispatched branch/jump ops and captures missing rs1/rs2 operands from the common data bus (CDB).
- Each cycle, issues the oldest fully-ready entry to the branch unit as a one-cycle registered issue pulse.
- Flushes all held entries on a pipeline kill (mispredict recovery).

Parameters:
- DEPTH, 4, number of entries; power of two, 2..8.
- TAG_W, 6, physical/ROB tag width.
- DATA_W, 32, operand and immediate width.
- PC_W, 32, PC and jump-address width.
- OP_W, 4, ALU op-select width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_disp_vld  in  1  dispatch request
- o_disp_rdy  out  1  entry free; dispatch accepted when vld&rdy
- i_disp_is_jal  in  1  JAL op
- i_disp_is_jalr  in  1  JALR op
- i_disp_alu_op  in  OP_W  compare op
- i_disp_pc  in  PC_W  instruction PC
- i_disp_imm  in  DATA_W  immediate
- i_disp_pred_jmpaddr  in  PC_W  predicted target
- i_disp_rs1_rdy  in  1  rs1 value valid at dispatch
- i_disp_rs1  in  DATA_W  rs1 value, or don't-care
- i_disp_rs1_tag  in  TAG_W  rs1 producer tag
- i_disp_rs2_rdy, i_disp_rs2, i_disp_rs2_tag  in  1/DATA_W/TAG_W  rs2, same as rs1
- i_cdb_vld  in  1  result broadcast
- i_cdb_tag  in  TAG_W  broadcast tag
- i_cdb_data  in  DATA_W  broadcast value
- i_ex_accessable  in  1  branch unit can accept an issue this cycle
- i_kill  in  1  flush all entries
- o_is_vld  out  1  issue pulse to branch unit
- o_is_jal, o_is_jalr, o_alu_op, o_rs1, o_rs2, o_pc, o_imm, o_pred_jmpaddr  out  match dispatch widths  issued op fields
- o_count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst_n=0 at posedge): all entries invalid; o_is_vld=0; o_count=0; all issue data outputs 0. o_disp_rdy=1 one cycle after reset is released.
- o_disp_rdy = (o_count != DEPTH). It is derived from registered occupancy only, so a slot freed by an issue this cycle is not reusable until next cycle.
- Allocation: an accepted dispatch writes the lowest-index free entry. The entry is valid from the next cycle.
- Age tracking: DEPTH x DEPTH age matrix. On allocation, the new entry is marked younger than every currently valid entry.
- Wakeup for held entries: for each valid entry and operand with rdy=0, if i_cdb_vld and tag==i_cdb_tag, latch i_cdb_data and set rdy. The entry is selectable no earlier than the following cycle.
- Wakeup at dispatch: if a dispatched operand has rdy=0 and its tag matches a valid CDB in the same cycle, it is stored as ready with i_cdb_data.
- Selection: an entry is ready when valid & rs1_rdy & rs2_rdy. The oldest ready entry, per the age matrix, is selected combinationally.
- Issue: if a ready entry exists and i_ex_accessable=1, then at the posedge:
  - the issue registers load the selected entry's fields;
  - o_is_vld=1 for exactly that cycle;
  - the entry is invalidated.
  Otherwise o_is_vld=0 and the data outputs hold their last values.
- Issue latency: one instruction at most per cycle. Minimum dispatch-to-o_is_vld latency is 2 cycles for an operand-ready op: cycle N accept, cycle N+1 select, o_is_vld high in cycle N+2.
- Simultaneous dispatch and issue in one cycle: both take effect; o_count is unchanged.
- Kill: i_kill=1 at a posedge does all of the following:
  - invalidates every entry;
  - clears o_is_vld;
  - ignores a concurrent dispatch (not accepted);
  - ignores a concurrent CDB write into entries;
  - sets o_count=0.
  Kill has priority over all other updates.
- i_ex_accessable=0: no entry is lost; selection retries each cycle.
- Full: when o_count==DEPTH, o_disp_rdy=0 and i_disp_vld is ignored.
- o_count: registered, equal to popcount of entry valid bits.

Test Plan:
- Reset then dispatch BEQ (pc=0x100, imm=8, rs1=5, rs2=5, both ready) at cycle 1 -> o_is_vld=1 at cycle 3 with o_pc=0x100, o_rs1=o_rs2=5, o_imm=8; o_count returns to 0.
- Dispatch A (rs1 tag 7 not ready), then B (ready); CDB tag 7 data 0x55 arrives later -> B issues first; A issues the cycle after wakeup plus 1 with o_rs1=0x55.
- Dispatch 4 ops, all waiting on tag 3 -> o_disp_rdy=0 and a 5th dispatch is not accepted; CDB tag 3 -> issue order equals dispatch order, one per cycle, 4 pulses.
- Dispatch with rs2 tag 9 not ready while CDB tag 9 data 0x1234 is valid in the same cycle -> issues 2 cycles later with o_rs2=0x1234.
- Hold i_ex_accessable=0 for 3 cycles with one ready entry -> no o_is_vld; issue occurs the cycle after accessable returns to 1.
- Three entries valid plus a dispatch and CDB in the same cycle as i_kill=1 -> o_count=0, o_is_vld=0 next cycle; no later issue until new dispatch.
